// File: rtl/mem_write_checker.sv
// Memory write checker: compares processor stores against an expected-write table in order.
// Optional watchdog timeout compiled in with MEM_WRITE_CHECKER_TIMEOUT_EN.
module mem_write_checker #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned TIMEOUT      = 1000,
  parameter int unsigned IGNORE_OTHER = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       exp_we,
  input  logic [$clog2(DEPTH)-1:0]   exp_idx,
  input  logic [WIDTH-1:0]           exp_addr,
  input  logic [WIDTH-1:0]           exp_data,
  input  logic [WIDTH-1:0]           exp_mask,
  input  logic [$clog2(DEPTH):0]     num_exp,
  input  logic                       start,
  input  logic                       clear,
  input  logic                       memwrite,
  input  logic [WIDTH-1:0]           dataadr,
  input  logic [WIDTH-1:0]           writedata,
  output logic                       busy,
  output logic                       pass,
  output logic                       fail,
  output logic [1:0]                 fail_code,
  output logic [$clog2(DEPTH)-1:0]   fail_idx,
  output logic [$clog2(DEPTH):0]     match_cnt
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam logic [1:0] CODE_NONE = 2'd0;
  localparam logic [1:0] CODE_ADDR = 2'd1;
  localparam logic [1:0] CODE_DATA = 2'd2;
`ifdef MEM_WRITE_CHECKER_TIMEOUT_EN
  localparam logic [1:0] CODE_TIME = 2'd3;
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
`endif

  if (DEPTH < 2 || DEPTH > 16 || TIMEOUT == 0) begin : g_param_check
    $error("mem_write_checker: DEPTH must be 2..16 and TIMEOUT nonzero");
  end

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_PASS, S_FAIL} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   num_q, num_d, num_clamp;
  logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
  logic [1:0]         fail_code_q, fail_code_d;
  logic [IDX_W-1:0]   fail_idx_q, fail_idx_d, ptr;
  logic               busy_q, busy_d, pass_q, pass_d, fail_q, fail_d;
  logic               addr_hit, data_hit;
  logic [WIDTH-1:0]   tbl_addr_q [DEPTH];
  logic [WIDTH-1:0]   tbl_data_q [DEPTH];
  logic [WIDTH-1:0]   tbl_mask_q [DEPTH];
  logic [WIDTH-1:0]   tbl_addr_d [DEPTH];
  logic [WIDTH-1:0]   tbl_data_d [DEPTH];
  logic [WIDTH-1:0]   tbl_mask_d [DEPTH];
`ifdef MEM_WRITE_CHECKER_TIMEOUT_EN
  logic [WD_W-1:0]    wdog_q, wdog_d;
`endif

  assign ptr       = match_cnt_q[IDX_W-1:0];
  assign num_clamp = (num_exp > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : num_exp;
  assign addr_hit  = (dataadr == tbl_addr_q[ptr]);
  assign data_hit  = (((writedata ^ tbl_data_q[ptr]) & tbl_mask_q[ptr]) == '0);

  // Next-state, table update and result outputs.
  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    match_cnt_d = match_cnt_q;
    fail_code_d = fail_code_q;
    fail_idx_d  = fail_idx_q;
    tbl_addr_d  = tbl_addr_q;
    tbl_data_d  = tbl_data_q;
    tbl_mask_d  = tbl_mask_q;
`ifdef MEM_WRITE_CHECKER_TIMEOUT_EN
    wdog_d      = wdog_q;
`endif
    if (state_q == S_IDLE && exp_we && ({1'b0, exp_idx} < CNT_W'(DEPTH))) begin
      tbl_addr_d[exp_idx] = exp_addr;
      tbl_data_d[exp_idx] = exp_data;
      tbl_mask_d[exp_idx] = exp_mask;
    end
    if (clear) begin
      state_d     = S_IDLE;
      match_cnt_d = '0;
      fail_code_d = CODE_NONE;
      fail_idx_d  = '0;
`ifdef MEM_WRITE_CHECKER_TIMEOUT_EN
      wdog_d      = '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            num_d       = num_clamp;
            match_cnt_d = '0;
            fail_code_d = CODE_NONE;
            fail_idx_d  = '0;
`ifdef MEM_WRITE_CHECKER_TIMEOUT_EN
            wdog_d      = '0;
`endif
            state_d     = (num_clamp == '0) ? S_PASS : S_ARMED;
          end
        end
        S_ARMED: begin
          if (memwrite && addr_hit && data_hit) begin
            match_cnt_d = match_cnt_q + CNT_W'(1);
`ifdef MEM_WRITE_CHECKER_TIMEOUT_EN
            wdog_d      = '0;
`endif
            if (match_cnt_q == num_q - CNT_W'(1)) state_d = S_PASS;
          end else if (memwrite && addr_hit) begin
            state_d     = S_FAIL;
            fail_code_d = CODE_DATA;
            fail_idx_d  = ptr;
          end else if (memwrite && IGNORE_OTHER == 0) begin
            state_d     = S_FAIL;
            fail_code_d = CODE_ADDR;
            fail_idx_d  = ptr;
          end
`ifdef MEM_WRITE_CHECKER_TIMEOUT_EN
          else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
            state_d     = S_FAIL;
            fail_code_d = CODE_TIME;
            fail_idx_d  = ptr;
          end else begin
            wdog_d      = wdog_q + WD_W'(1);
          end
`endif
        end
        default: ;
      endcase
    end
    busy_d = (state_d == S_ARMED);
    pass_d = (state_d == S_PASS);
    fail_d = (state_d == S_FAIL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      num_q       <= '0;
      match_cnt_q <= '0;
      fail_code_q <= CODE_NONE;
      fail_idx_q  <= '0;
      busy_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      match_cnt_q <= match_cnt_d;
      fail_code_q <= fail_code_d;
      fail_idx_q  <= fail_idx_d;
      busy_q      <= busy_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
    end
  end

  // Expected-write table survives reset so a run can be repeated after an abort.
  always_ff @(posedge clk) begin
    tbl_addr_q <= tbl_addr_d;
    tbl_data_q <= tbl_data_d;
    tbl_mask_q <= tbl_mask_d;
  end

`ifdef MEM_WRITE_CHECKER_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wdog_q <= '0;
    else       wdog_q <= wdog_d;
  end
`endif

  assign busy      = busy_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign fail_code = fail_code_q;
  assign fail_idx  = fail_idx_q;
  assign match_cnt = match_cnt_q;
endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker: two instances (IGNORE_OTHER 0 and 1) share all inputs.
module tb_mem_write_checker;
  logic        clk, reset;
  logic        exp_we, start, clear, memwrite;
  logic [1:0]  exp_idx;
  logic [31:0] exp_addr, exp_data, exp_mask, dataadr, writedata;
  logic [2:0]  num_exp;
  logic        busy0, pass0, fail0, busy1, pass1, fail1;
  logic [1:0]  code0, code1, idx0, idx1;
  logic [2:0]  cnt0, cnt1;
  logic [9:0]  s0, s1, e0, e1;
  int          passed, total;

  mem_write_checker #(.WIDTH(32), .DEPTH(4), .TIMEOUT(20), .IGNORE_OTHER(0)) dut0 (
    .clk(clk), .reset(reset), .exp_we(exp_we), .exp_idx(exp_idx), .exp_addr(exp_addr),
    .exp_data(exp_data), .exp_mask(exp_mask), .num_exp(num_exp), .start(start), .clear(clear),
    .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata), .busy(busy0), .pass(pass0),
    .fail(fail0), .fail_code(code0), .fail_idx(idx0), .match_cnt(cnt0));

  mem_write_checker #(.WIDTH(32), .DEPTH(4), .TIMEOUT(20), .IGNORE_OTHER(1)) dut1 (
    .clk(clk), .reset(reset), .exp_we(exp_we), .exp_idx(exp_idx), .exp_addr(exp_addr),
    .exp_data(exp_data), .exp_mask(exp_mask), .num_exp(num_exp), .start(start), .clear(clear),
    .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata), .busy(busy1), .pass(pass1),
    .fail(fail1), .fail_code(code1), .fail_idx(idx1), .match_cnt(cnt1));

  assign s0 = {busy0, pass0, fail0, code0, idx0, cnt0};
  assign s1 = {busy1, pass1, fail1, code1, idx1, cnt1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] st(input logic b, input logic p, input logic f,
                                    input logic [1:0] c, input logic [1:0] i, input logic [2:0] m);
    return {b, p, f, c, i, m};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load_entry(input logic [1:0] i, input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] m);
    exp_we = 1'b1; exp_idx = i; exp_addr = a; exp_data = d; exp_mask = m;
    tick();
    exp_we = 1'b0;
  endtask

  task automatic arm(input logic [2:0] n);
    start = 1'b1; num_exp = n;
    tick();
    start = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1; dataadr = a; writedata = d;
    tick();
    memwrite = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    e0 = st(0, 0, 0, 0, 0, 0); e1 = e0; total++;
    if ({s0, s1} !== {e0, e1}) $display("FAIL reset_state: got %h %h exp %h %h", s0, s1, e0, e1); else passed++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_pass();
    load_entry(2'd0, 32'd80, 32'hFFFF_FFFA, 32'hFFFF_FFFF);
    arm(3'd1);
    e0 = st(1, 0, 0, 0, 0, 0); e1 = e0; total++;
    if ({s0, s1} !== {e0, e1}) $display("FAIL basic_armed: got %h %h exp %h %h", s0, s1, e0, e1); else passed++;
    tick();
    e0 = st(1, 0, 0, 0, 0, 0); e1 = e0; total++;
    if ({s0, s1} !== {e0, e1}) $display("FAIL idle_memwrite_low: got %h %h exp %h %h", s0, s1, e0, e1); else passed++;
    store(32'd80, 32'hFFFF_FFFA);
    e0 = st(0, 1, 0, 0, 0, 1); e1 = e0; total++;
    if ({s0, s1} !== {e0, e1}) $display("FAIL basic_pass: got %h %h exp %h %h", s0, s1, e0, e1); else passed++;
  endtask

  task automatic test_data_fail();
    do_clear();
    e0 = st(0, 0, 0, 0, 0, 0); e1 = e0; total++;
    if ({s0, s1} !== {e0, e1}) $display("FAIL clear_after_pass: got %h %h exp %h %h", s0, s1, e0, e1); else passed++;
    arm(3'd1);
    store(32'd80, 32'hFFFF_FF7A);
    e0 = st(0, 0, 1, 2, 0, 0); e1 = e0; total++;
    if ({s0, s1} !== {e0, e1}) $display("FAIL data_fail: got %h %h exp %h %h", s0, s1, e0, e1); else passed++;
    arm(3'd1);
    store(32'd80, 32'hFFFF_FFFA);
    e0 = st(0, 0, 1, 2, 0, 0); e1 = e0; total++;
    if ({s0, s1} !== {e0, e1}) $display("FAIL fail_sticky: got %h %h exp %h %h", s0, s1, e0, e1); else passed++;
  endtask

  task automatic test_addr_mismatch();
    do_clear();
    arm(3'd1);
    store(32'd84, 32'hFFFF_FFFA);
    e0 = st(0, 0, 1, 1, 0, 0); e1 = st(1, 0, 0, 0, 0, 0); total++;
    if ({s0, s1} !== {e0, e1}) $display("FAIL addr_mismatch: got %h %h exp %h %h", s0, s1, e0, e1); else passed++;
    store(32'd80, 32'hFFFF_FFFA);
    e0 = st(0, 0, 1, 1, 0, 0); e1 = st(0, 1, 0, 0, 0, 1); total++;
    if ({s0, s1} !== {e0, e1}) $display("FAIL ignore_then_pass: got %h %h exp %h %h", s0, s1, e0, e1); else passed++;
  endtask

  task automatic test_masked_multi();
    do_clear();
    load_entry(2'd0, 32'h100, 32'hAAAA_AA78, 32'h0000_00FF);
    load_entry(2'd1, 32'h104, 32'h0000_00AB, 32'h0000_00FF);
    load_entry(2'd2, 32'h108, 32'h1111_1180, 32'h0000_00FF);
    arm(3'd3);
    store(32'h100, 32'h1234_5678);
    e0 = st(1, 0, 0, 0, 0, 1); e1 = e0; total++;
    if ({s0, s1} !== {e0, e1}) $display("FAIL masked_first: got %h %h exp %h %h", s0, s1, e0, e1); else passed++;
    tick();
    store(32'h104, 32'h0000_00AB);
    e0 = st(1, 0, 0, 0, 0, 2); e1 = e0; total++;
    if ({s0, s1} !== {e0, e1}) $display("FAIL masked_second: got %h %h exp %h %h", s0, s1, e0, e1); else passed++;
    store(32'h108, 32'hFFFF_FF80);
    e0 = st(0, 1, 0, 0, 0, 3); e1 = e0; total++;
    if ({s0, s1} !== {e0, e1}) $display("FAIL masked_pass: got %h %h exp %h %h", s0, s1, e0, e1); else passed++;
    do_clear();
    arm(3'd3);
    store(32'h100, 32'h1234_5678);
    store(32'h104, 32'h0000_00AC);
    e0 = st(0, 0, 1, 2, 1, 1); e1 = e0; total++;
    if ({s0, s1} !== {e0, e1}) $display("FAIL masked_fail_idx1: got %h %h exp %h %h", s0, s1, e0, e1); else passed++;
  endtask

  task automatic test_zero_and_clamp();
    do_clear();
    arm(3'd0);
    e0 = st(0, 1, 0, 0, 0, 0); e1 = e0; total++;
    if ({s0, s1} !== {e0, e1}) $display("FAIL num_zero_pass: got %h %h exp %h %h", s0, s1, e0, e1); else passed++;
    do_clear();
    load_entry(2'd3, 32'h10C, 32'h0000_0055, 32'h0000_00FF);
    arm(3'd7);
    store(32'h100, 32'h1234_5678);
    store(32'h104, 32'h0000_00AB);
    store(32'h108, 32'hFFFF_FF80);
    e0 = st(1, 0, 0, 0, 0, 3); e1 = e0; total++;
    if ({s0, s1} !== {e0, e1}) $display("FAIL clamp_three: got %h %h exp %h %h", s0, s1, e0, e1); else passed++;
    store(32'h10C, 32'hCDEF_0055);
    e0 = st(0, 1, 0, 0, 0, 4); e1 = e0; total++;
    if ({s0, s1} !== {e0, e1}) $display("FAIL clamp_pass: got %h %h exp %h %h", s0, s1, e0, e1); else passed++;
  endtask

  task automatic test_timeout();
    do_clear();
    arm(3'd1);
    repeat (19) tick();
    e0 = st(1, 0, 0, 0, 0, 0); e1 = e0; total++;
    if ({s0, s1} !== {e0, e1}) $display("FAIL timeout_early: got %h %h exp %h %h", s0, s1, e0, e1); else passed++;
    tick();
`ifdef MEM_WRITE_CHECKER_TIMEOUT_EN
    e0 = st(0, 0, 1, 3, 0, 0); e1 = e0; total++;
    if ({s0, s1} !== {e0, e1}) $display("FAIL timeout_fire: got %h %h exp %h %h", s0, s1, e0, e1); else passed++;
`else
    repeat (80) tick();
    e0 = st(1, 0, 0, 0, 0, 0); e1 = e0; total++;
    if ({s0, s1} !== {e0, e1}) $display("FAIL no_timeout: got %h %h exp %h %h", s0, s1, e0, e1); else passed++;
`endif
  endtask

  task automatic test_reset_and_priority();
    do_clear();
    arm(3'd1);
    tick(); tick();
    reset = 1'b1;
    #1;
    e0 = st(0, 0, 0, 0, 0, 0); e1 = e0; total++;
    if ({s0, s1} !== {e0, e1}) $display("FAIL async_reset: got %h %h exp %h %h", s0, s1, e0, e1); else passed++;
    tick();
    reset = 1'b0;
    clear = 1'b1; start = 1'b1; num_exp = 3'd1;
    tick();
    clear = 1'b0; start = 1'b0;
    e0 = st(0, 0, 0, 0, 0, 0); e1 = e0; total++;
    if ({s0, s1} !== {e0, e1}) $display("FAIL clear_over_start: got %h %h exp %h %h", s0, s1, e0, e1); else passed++;
    arm(3'd1);
    clear = 1'b1; memwrite = 1'b1; dataadr = 32'h100; writedata = 32'h1234_5678;
    tick();
    clear = 1'b0; memwrite = 1'b0;
    e0 = st(0, 0, 0, 0, 0, 0); e1 = e0; total++;
    if ({s0, s1} !== {e0, e1}) $display("FAIL clear_over_memwrite: got %h %h exp %h %h", s0, s1, e0, e1); else passed++;
    arm(3'd1);
    store(32'h100, 32'h1234_5678);
    e0 = st(0, 1, 0, 0, 0, 1); e1 = e0; total++;
    if ({s0, s1} !== {e0, e1}) $display("FAIL table_kept: got %h %h exp %h %h", s0, s1, e0, e1); else passed++;
  endtask

  initial begin
    passed = 0; total = 0;
    reset = 1'b1; exp_we = 1'b0; start = 1'b0; clear = 1'b0; memwrite = 1'b0;
    exp_idx = '0; exp_addr = '0; exp_data = '0; exp_mask = '0; num_exp = '0;
    dataadr = '0; writedata = '0;
    test_reset();
    test_basic_pass();
    test_data_fail();
    test_addr_mismatch();
    test_masked_multi();
    test_zero_and_clamp();
    test_timeout();
    test_reset_and_priority();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, passed %0d of %0d", passed, total);
    $fatal(1);
  end
endmodule
